// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared defaults, stats widths and count-width helper for fifo_rd_stream
package fifo_rd_pkg;

  localparam int DEF_BUF_DEPTH = 4;
  localparam int STAT_WORDS_W  = 32;
  localparam int STAT_STALLS_W = 16;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// rtl/rd_skid_buf.sv - ring buffer holding landed FIFO words, presented as a valid/ready stream head
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = DEF_BUF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     ready,
  output logic                     valid,
  output logic [DATA_WIDTH-1:0]    data,
  output logic [cnt_w(DEPTH)-1:0]  count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  pop;

  assign pop   = valid && ready;
  assign valid = (count != '0);
  assign data  = mem[rd_ptr];

  // Storage is deliberately not reset; only occupancy decides validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      assert (!(wr_en && count == CW'(DEPTH)));
      assert (count <= CW'(DEPTH));
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - credit-based FIFO read adapter to valid/ready stream; optional stats via FIFO_RD_STATS_EN
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = DEF_BUF_DEPTH
) (
  input  logic                         rclk,
  input  logic                         rrst,
  input  logic                         fifo_empty,
  input  logic [DATA_WIDTH-1:0]        fifo_data,
  output logic                         fifo_r_en,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [cnt_w(BUF_DEPTH)-1:0]  buf_count
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [STAT_WORDS_W-1:0]      stat_words,
  output logic [STAT_STALLS_W-1:0]     stat_stalls
`endif
);

  localparam int CW = cnt_w(BUF_DEPTH);

  logic          inflight;
  logic          fire;
  logic [CW:0]   credit;

  // Credit counts the word still in flight so the buffer can never overflow;
  // m_ready deliberately does not enter this path.
  assign credit    = {1'b0, buf_count} + {{CW{1'b0}}, inflight};
  assign fire      = !rrst && !fifo_empty && (credit < (CW+1)'(BUF_DEPTH));
  assign fifo_r_en = fire;

  always_ff @(posedge rclk) begin
    if (rrst) inflight <= 1'b0;
    else      inflight <= fire;
  end

  rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH)
  ) u_buf (
    .clk     (rclk),
    .rst     (rrst),
    .wr_en   (inflight),
    .wr_data (fifo_data),
    .ready   (m_ready),
    .valid   (m_valid),
    .data    (m_data),
    .count   (buf_count)
  );

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge rclk) begin
    if (rrst) begin
      stat_words  <= '0;
      stat_stalls <= '0;
    end else begin
      if (m_valid && m_ready) stat_words <= stat_words + STAT_WORDS_W'(1);
      if (m_valid && !m_ready && stat_stalls != '1)
        stat_stalls <= stat_stalls + STAT_STALLS_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - directed and randomized checks of fifo_rd_stream against a queue model
module tb_fifo_rd_stream;

  logic       rclk;
  logic       rrst;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_r_en;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [2:0] buf_count;
`ifdef FIFO_RD_STATS_EN
  logic [31:0] stat_words;
  logic [15:0] stat_stalls;
`endif

  fifo_rd_stream #(.DATA_WIDTH(8), .BUF_DEPTH(4)) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .buf_count  (buf_count)
`ifdef FIFO_RD_STATS_EN
    ,
    .stat_words (stat_words),
    .stat_stalls(stat_stalls)
`endif
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int vectors = 0;
  int errors  = 0;

  // Model: src = words still in the FIFO, exp_q = words read but not yet consumed
  logic [7:0] src[$];
  logic [7:0] exp_q[$];
  int  ref_count = 0;
  bit  pending   = 0;
  int  mode      = 0;   // 0: ready low, 1: ready high, 2: random ready
  bit  bubble    = 0;
  int  cyc       = 0;
  int  pops      = 0;
  int  first_fire_cyc = -1;
  int  last_pop_cyc   = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_inputs();
    m_ready    = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(1)) : 1'b0;
    fifo_empty = (src.size() == 0) || (bubble && $urandom_range(3) == 0);
  endtask

  task automatic cycle();
    bit fire_now, pop_now;
    logic [7:0] w;
    if (!rrst) begin
      chk("fire", fifo_r_en, 32'(!fifo_empty && (ref_count + int'(pending)) < 4));
      chk("valid", m_valid, 32'(ref_count != 0));
      chk("count", buf_count, ref_count);
      chk("count_max", 32'(buf_count <= 3'd4), 1);
      if (ref_count != 0) chk("data", m_data, exp_q[0]);
    end else begin
      chk("rst_fire", fifo_r_en, 0);
    end
    chk("no_read_when_empty", 32'(fifo_r_en && fifo_empty), 0);
    fire_now = fifo_r_en;
    pop_now  = m_valid && m_ready && !rrst;
    if (fire_now && first_fire_cyc < 0) first_fire_cyc = cyc;
    @(posedge rclk);
    #1;
    if (rrst) begin
      exp_q.delete();
      ref_count = 0;
      pending   = 0;
      fifo_data = 8'($urandom);
    end else begin
      if (pop_now && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        ref_count--;
        pops++;
        last_pop_cyc = cyc;
      end
      if (pending) ref_count++;
      pending = fire_now;
      if (fire_now && src.size() != 0) begin
        w = src.pop_front();
        exp_q.push_back(w);
        fifo_data = w;
      end else begin
        fifo_data = 8'($urandom);
      end
    end
    cyc++;
    set_inputs();
    #1;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((src.size() != 0 || exp_q.size() != 0) && n < bound) begin
      cycle();
      n++;
    end
    chk("drain_timeout", 32'(n < bound), 1);
  endtask

  initial begin
    rrst = 1'b1; m_ready = 1'b0; fifo_empty = 1'b1; fifo_data = 8'h00;
    for (int i = 1; i <= 16; i++) src.push_back(8'(i));
    set_inputs();
    @(posedge rclk);
    #1;

    // Reset with a non-empty FIFO: nothing may be read
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_valid", m_valid, 0);
      chk("rst_count", buf_count, 0);
    end
    rrst = 1'b0;
    mode = 1;
    set_inputs();
    #1;
    chk("first_fire", fifo_r_en, 1);

    // Streaming 0x01..0x10 back to back
    pops = 0; first_fire_cyc = -1;
    for (int i = 0; i < 20; i++) cycle();
    chk("stream_pops", pops, 16);
    chk("stream_latency", last_pop_cyc - first_fire_cyc, 17);

    // Backpressure: fill to depth, hold, then drain
    for (int i = 0; i < 16; i++) src.push_back(8'h20 + 8'(i));
    set_inputs();
    #1;
    for (int i = 0; i < 4; i++) cycle();
    mode = 0;
    set_inputs();
    #1;
    for (int i = 0; i < 8; i++) cycle();
    chk("bp_count", buf_count, 4);
    chk("bp_ren", fifo_r_en, 0);
    chk("bp_valid", m_valid, 1);
    mode = 1;
    set_inputs();
    #1;
    drain(100);

    // Empty bubble after word 0x05, then resume with 0x06..
    pops = 0;
    for (int i = 1; i <= 5; i++) src.push_back(8'(i));
    set_inputs();
    #1;
    drain(50);
    for (int i = 0; i < 3; i++) cycle();
    chk("bubble_valid", m_valid, 0);
    for (int i = 6; i <= 10; i++) src.push_back(8'(i));
    set_inputs();
    #1;
    drain(50);
    chk("bubble_pops", pops, 10);

    // Random words, random ready and random empty bubbles across many wraps
    pops = 0;
    for (int i = 0; i < 1000; i++) src.push_back(8'($urandom));
    mode = 2;
    bubble = 1;
    set_inputs();
    #1;
    drain(10000);
    chk("wrap_pops", pops, 1000);

    // Reset while holding three words plus one in flight
    bubble = 0;
    mode = 0;
    for (int i = 0; i < 10; i++) src.push_back(8'h80 + 8'(i));
    set_inputs();
    #1;
    begin
      int n = 0;
      while (!(ref_count == 3 && pending) && n < 20) begin
        cycle();
        n++;
      end
      chk("reach_3_inflight", 32'(n < 20), 1);
    end
    rrst = 1'b1;
    cycle();
    chk("mid_rst_count", buf_count, 0);
    chk("mid_rst_valid", m_valid, 0);
`ifdef FIFO_RD_STATS_EN
    chk("mid_rst_words", stat_words, 0);
    chk("mid_rst_stalls", stat_stalls, 0);
`endif
    rrst = 1'b0;
    mode = 1;
    set_inputs();
    #1;
    drain(100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
